turn_scheduler: RTL and testbench

- Synchronous turn controller for the 6-player elimination game.
- Replaces the mux-selected player-button clock with a single system clock, so the whole game runs on one clock domain.
- Synchronizes and edge-detects six asynchronous player buttons, grants only the current player, applies the move table, and times out idle players.
- Produces the same state/out encoding the game display logic consumes.

---
 rtl/turn_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_turn_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - single-clock turn controller for the 6-player elimination game
//
// Purpose:
//   Synchronizes and edge-detects six asynchronous player buttons, grants only
//   the current player, applies the move table and times out idle players.
//   Everything runs on clk; the display logic consumes state_out/out unchanged.
//
// Optional feature macro: WRONG_TURN_LOSE_EN
//   Defined   : an out-of-turn press during play makes the lowest-index wrong
//               presser lose, overriding the current move and the timeout.
//   Undefined : out-of-turn presses only pulse wrong_turn.
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   player_btn[5:0] raw asynchronous buttons, bit k-1 = player k
//   player1..6     3-bit action code of each player
//   state_out[3:0] {lose, id}; id = current player, or loser when lose=1
//   out[2:0]       loser id when lose=1, else 0
//   grant[5:0]     one-hot current player, 0 while lose=1
//   move_pulse     one-cycle pulse per accepted move
//   lose_pulse     one-cycle pulse on entry to the lose state
//   wrong_turn[5:0] one-cycle pulse per out-of-turn press edge

module turn_scheduler #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] player_btn,
  input  logic [2:0] player1,
  input  logic [2:0] player2,
  input  logic [2:0] player3,
  input  logic [2:0] player4,
  input  logic [2:0] player5,
  input  logic [2:0] player6,
  output logic [3:0] state_out,
  output logic [2:0] out,
  output logic [5:0] grant,
  output logic       move_pulse,
  output logic       lose_pulse,
  output logic [5:0] wrong_turn
);

  typedef enum logic {PLAY = 1'b0, LOSE = 1'b1} phase_t;

  phase_t                 phase_q, phase_d;
  logic [2:0]             id_q, id_d;
  logic [TIMEOUT_W-1:0]   tcnt_q, tcnt_d;
  logic                   move_d, lose_d;
  logic [5:0]             wt_d;

  logic [5:0]             sync_q [SYNC_STAGES];
  logic [5:0]             prev_q;
  logic [5:0]             btn_edge;
  logic [5:0]             id_onehot;
  logic                   own_edge;
  logic [2:0]             action;
  logic                   timeout_hit;

`ifdef WRONG_TURN_LOSE_EN
  logic [2:0]             low_j;
`endif

  // Player ids are 1..6; advance k by step positions with wrap-around.
  function automatic logic [2:0] id_step(input logic [2:0] k, input logic [2:0] step);
    logic [3:0] s;
    s = {1'b0, k} + {1'b0, step};
    if (s > 4'd6) s = s - 4'd6;
    return s[2:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= player_btn;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign btn_edge  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign id_onehot = 6'b000001 << (id_q - 3'd1);
  assign own_edge  = |(btn_edge & id_onehot);

  always_comb begin
    case (id_q)
      3'd1:    action = player1;
      3'd2:    action = player2;
      3'd3:    action = player3;
      3'd4:    action = player4;
      3'd5:    action = player5;
      3'd6:    action = player6;
      default: action = player1;
    endcase
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      assign timeout_hit = (tcnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

  always_comb begin
    phase_d = phase_q;
    id_d    = id_q;
    move_d  = 1'b0;
    lose_d  = 1'b0;
    wt_d    = '0;
`ifdef WRONG_TURN_LOSE_EN
    low_j   = 3'd1;
`endif
    case (phase_q)
      PLAY: begin
        wt_d = btn_edge & ~id_onehot;
        if (own_edge) begin
          move_d = 1'b1;
          case (action)
            3'd1:    id_d = id_step(id_q, 3'd4);
            3'd2:    id_d = id_step(id_q, 3'd5);
            3'd4:    id_d = id_step(id_q, 3'd1);
            3'd5:    id_d = id_step(id_q, 3'd2);
            default: begin
              phase_d = LOSE;
              lose_d  = 1'b1;
            end
          endcase
        end else if (timeout_hit) begin
          phase_d = LOSE;
          lose_d  = 1'b1;
        end
`ifdef WRONG_TURN_LOSE_EN
        for (int j = 5; j >= 0; j--) begin
          if (wt_d[j]) low_j = 3'(j + 1);
        end
        if (|wt_d) begin
          phase_d = LOSE;
          id_d    = low_j;
          lose_d  = 1'b1;
          move_d  = 1'b0;
        end
`endif
      end
      LOSE: begin
        // Only the loser can restart; the game resumes with player 1.
        if (own_edge) begin
          phase_d = PLAY;
          id_d    = 3'd1;
          move_d  = 1'b1;
        end
      end
      default: begin
        phase_d = PLAY;
        id_d    = 3'd1;
      end
    endcase

    if (phase_d != phase_q || id_d != id_q || phase_q == LOSE) tcnt_d = '0;
    else if (TIMEOUT_CYCLES != 0)                              tcnt_d = tcnt_q + TIMEOUT_W'(1);
    else                                                       tcnt_d = tcnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= PLAY;
      id_q       <= 3'd1;
      tcnt_q     <= '0;
      move_pulse <= 1'b0;
      lose_pulse <= 1'b0;
      wrong_turn <= '0;
    end else begin
      phase_q    <= phase_d;
      id_q       <= id_d;
      tcnt_q     <= tcnt_d;
      move_pulse <= move_d;
      lose_pulse <= lose_d;
      wrong_turn <= wt_d;
    end
  end

  assign state_out = {phase_q == LOSE, id_q};
  assign out       = (phase_q == LOSE) ? id_q : 3'b000;
  assign grant     = (phase_q == LOSE) ? 6'b000000 : id_onehot;

endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - randomized bench for turn_scheduler against a game-rule model

module tb_turn_scheduler;

  localparam int S  = 2;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] btn = '0;
  logic [2:0] act [6];
  logic [3:0] state_out;
  logic [2:0] out;
  logic [5:0] grant;
  logic       move_pulse;
  logic       lose_pulse;
  logic [5:0] wrong_turn;

  always #5 clk = ~clk;

  turn_scheduler #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(TO), .TIMEOUT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .player_btn(btn),
    .player1(act[0]), .player2(act[1]), .player3(act[2]),
    .player4(act[3]), .player5(act[4]), .player6(act[5]),
    .state_out(state_out), .out(out), .grant(grant),
    .move_pulse(move_pulse), .lose_pulse(lose_pulse), .wrong_turn(wrong_turn)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Game model: button history per sampled edge, game state and idle reference.
  bit         m_lose;
  int         m_id;
  logic       m_mp, m_lp;
  logic [5:0] m_wt;
  logic [5:0] hist [S+2];
  int         n_edge = 0;
  int         last_change = 0;

  task automatic model_reset();
    m_lose = 0; m_id = 1; m_mp = 0; m_lp = 0; m_wt = '0;
    for (int i = 0; i < S + 2; i++) hist[i] = '0;
    last_change = n_edge;
  endtask

  task automatic model_edge();
    logic [5:0] rise;
    bit         n_lose;
    int         n_id;
    n_edge++;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = btn;
    // A press seen at edge n-S is acted upon at edge n.
    rise = hist[S] & ~hist[S+1];
    n_lose = m_lose; n_id = m_id;
    m_mp = 0; m_lp = 0; m_wt = '0;
    if (!m_lose) begin
      m_wt = rise;
      m_wt[m_id-1] = 1'b0;
      if (rise[m_id-1]) begin
        m_mp = 1;
        case (act[m_id-1])
          3'd1: n_id = ((m_id + 3) % 6) + 1;
          3'd2: n_id = (m_id == 1) ? 6 : m_id - 1;
          3'd4: n_id = (m_id == 6) ? 1 : m_id + 1;
          3'd5: n_id = ((m_id + 1) % 6) + 1;
          default: begin n_lose = 1; m_lp = 1; end
        endcase
      end else if (TO != 0 && n_edge - last_change == TO) begin
        n_lose = 1; m_lp = 1;
      end
`ifdef WRONG_TURN_LOSE_EN
      if (m_wt != 0) begin
        n_lose = 1; m_lp = 1; m_mp = 0;
        for (int j = 6; j >= 1; j--) if (m_wt[j-1]) n_id = j;
      end
`endif
    end else if (rise[m_id-1]) begin
      n_lose = 0; n_id = 1; m_mp = 1;
    end
    if (n_lose != m_lose || n_id != m_id) last_change = n_edge;
    m_lose = n_lose; m_id = n_id;
  endtask

  task automatic compare_all();
    logic [2:0] id3;
    id3 = 3'(m_id);
    check("state_out", state_out, {m_lose, id3});
    check("out", out, m_lose ? id3 : 3'd0);
    check("grant", grant, m_lose ? 6'd0 : (6'd1 << (m_id - 1)));
    check("move_pulse", move_pulse, m_mp);
    check("lose_pulse", lose_pulse, m_lp);
    check("wrong_turn", wrong_turn, m_wt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1 compare_all();
    step();
    step();
    reset_n = 1'b1;
  endtask

  logic [3:0] snap_state;
  logic [2:0] snap_out;
  logic       snap_mp, snap_lp;
  logic [5:0] snap_wt;

  task automatic press(input int k, input logic [2:0] a);
    act[k-1] = a;
    btn[k-1] = 1'b1;
    repeat (3) step();
    snap_state = state_out; snap_out = out;
    snap_mp = move_pulse; snap_lp = lose_pulse; snap_wt = wrong_turn;
    btn[k-1] = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    int mp_cnt;
    for (int i = 0; i < 6; i++) act[i] = 3'd4;
    model_reset();
    @(negedge clk);
    do_reset();
    step();
    check("rst_state", state_out, 4'b0001);
    check("rst_grant", grant, 6'b000001);
    check("rst_out", out, 3'd0);

    // Latency and held button
    act[0] = 3'd4; btn[0] = 1'b1;
    step(); check("lat_e1", state_out, 4'b0001);
    step(); check("lat_e2", state_out, 4'b0001);
    step(); check("lat_e3", state_out, 4'b0010); check("lat_mp", move_pulse, 1'b1);
    mp_cnt = 0;
    repeat (20) begin step(); mp_cnt += int'(move_pulse); end
    check("hold_no_move", mp_cnt, 0);
    check("hold_timeout", state_out, 4'b1010);
    btn[0] = 1'b0; step(); step();

    // Move table walk, lose and restart
    do_reset();
    press(1, 3'd5); check("mv_1_5", snap_state, 4'b0011);
    press(3, 3'd5); check("mv_3_5", snap_state, 4'b0101);
    press(5, 3'd4); check("mv_5_4", snap_state, 4'b0110);
    press(6, 3'd1); check("mv_6_1", snap_state, 4'b0100);
    press(4, 3'd2); check("mv_4_2", snap_state, 4'b0011);
    press(3, 3'd7); check("lose_state", snap_state, 4'b1011);
    check("lose_out", snap_out, 3'd3); check("lose_lp", snap_lp, 1'b1); check("lose_mp", snap_mp, 1'b1);
    press(2, 3'd4); check("lose_ign", snap_state, 4'b1011); check("lose_ign_wt", snap_wt, 6'd0);
    press(3, 3'd0); check("restart", snap_state, 4'b0001); check("restart_mp", snap_mp, 1'b1);

    // Timeout and move-beats-timeout
    do_reset();
    repeat (7) step(); check("to_pre", state_out, 4'b0001);
    step(); check("to_fire", state_out, 4'b1001); check("to_lp", lose_pulse, 1'b1);
    do_reset();
    act[0] = 3'd4;
    repeat (5) step();
    btn[0] = 1'b1;
    repeat (3) step();
    check("to_move_wins", state_out, 4'b0010); check("to_move_lp", lose_pulse, 1'b0);
    btn[0] = 1'b0; step(); step();

    // Simultaneous edges from player 2 and player 5
    do_reset();
    press(1, 3'd4);
    act[1] = 3'd4; btn = 6'b010010;
    repeat (3) step();
`ifdef WRONG_TURN_LOSE_EN
    check("simul_state", state_out, 4'b1101); check("simul_mp", move_pulse, 1'b0);
`else
    check("simul_state", state_out, 4'b0011); check("simul_wt", wrong_turn, 6'b010000);
`endif
    btn = '0; step(); step();

    // Randomized play
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
        if ($urandom_range(0, 29) == 0)
          act[i] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                                : ((($urandom & 1) != 0) ? 3'd4 : 3'd5);
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
